// File: rtl/rx_ctrl_pkg.sv
// rx_ctrl_pkg
// Shared definitions for the receive frame controller: controller state
// encoding, default buffer depth and checksum timeout, frame word width,
// and a saturating 8-bit increment used by the drop counter.
package rx_ctrl_pkg;

    localparam int WORD_W          = 32;
    localparam int DIBITS_PER_WORD = WORD_W / 2;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_TIMEOUT     = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WAIT_CK = 2'd2,
        DRAIN   = 2'd3
    } rx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_frame_ctrl_dibit_pack.sv
// dibit_pack
// Packs 16 consecutive dibits into one 32-bit word; the first dibit lands in
// the most significant position.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   clear       drop any partially packed word (count returns to 0)
//   in_valid    shift in_data into the packer this cycle
//   in_data     dibit to shift in
//   word        assembled word, valid while word_valid is high
//   word_valid  high in the cycle the 16th dibit of a word is presented
module dibit_pack
    import rx_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [1:0]        in_data,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    localparam int CW = $clog2(DIBITS_PER_WORD);

    // Only the first 15 dibits need storage; the 16th is taken straight from
    // in_data so the word can be written in the same cycle it completes.
    logic [WORD_W-3:0] shift_reg;
    logic [CW-1:0]     cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else if (clear) begin
            cnt_reg   <= '0;
        end else if (in_valid) begin
            shift_reg <= {shift_reg[WORD_W-5:0], in_data};
            cnt_reg   <= cnt_reg + CW'(1);   // wraps to 0 after a full word
        end
    end

    assign word       = {shift_reg, in_data};
    assign word_valid = in_valid && !clear && (cnt_reg == CW'(DIBITS_PER_WORD - 1));

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl
// Collects a dibit stream into a word buffer, waits for the checksum verdict,
// then either drains the frame downstream with valid/ready handshaking or
// discards it and counts the drop.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   axiiv, axiid       dibit stream from the firewall stage
//   ck_done, ck_kill   checksum verdict strobe and fail flag
//   out_ready          downstream accepts the current word
//   out_valid/data/last  committed frame word, last-word marker
//   frame_ok           one-cycle pulse when a frame has fully drained
//   frame_drop         one-cycle pulse when a frame is discarded
//   busy               controller is waiting for a verdict or draining
//   drop_cnt           saturating count of discarded frames
module rx_frame_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [1:0]        axiid,
    input  logic              ck_done,
    input  logic              ck_kill,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_ok,
    output logic              frame_drop,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    rx_state_t         state_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [TW-1:0]     timer_reg;
    logic              overflow_reg;
    logic              done_lat_reg;
    logic              kill_lat_reg;
    logic [WORD_W-1:0] frame_mem [DEPTH];

    logic              pack_en;
    logic [WORD_W-1:0] pack_word;
    logic              pack_word_valid;
    logic              frame_bad;

    // Dibits are accepted only while idle (first dibit of a frame) or
    // collecting; any other time the packer is held empty.
    assign pack_en = axiiv && ((state_reg == IDLE) || (state_reg == COLLECT));

    dibit_pack u_pack (
        .clk        (clk),
        .rst        (rst),
        .clear      (!pack_en),
        .in_valid   (pack_en),
        .in_data    (axiid),
        .word       (pack_word),
        .word_valid (pack_word_valid)
    );

    // Words beyond DEPTH are not stored; the frame is marked overflowed instead.
    always_ff @(posedge clk) begin
        if (pack_word_valid && (wr_ptr_reg != PW'(DEPTH)))
            frame_mem[wr_ptr_reg[AW-1:0]] <= pack_word;
    end

    assign busy      = (state_reg == WAIT_CK) || (state_reg == DRAIN);
    // Overflowed or empty frames can never be delivered, so they are dropped
    // without waiting for the verdict.
    assign frame_bad = overflow_reg || (wr_ptr_reg == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            timer_reg    <= '0;
            overflow_reg <= 1'b0;
            done_lat_reg <= 1'b0;
            kill_lat_reg <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_last     <= 1'b0;
            frame_ok     <= 1'b0;
            frame_drop   <= 1'b0;
            drop_cnt     <= '0;
        end else begin
            frame_ok   <= 1'b0;
            frame_drop <= 1'b0;

            // A verdict may arrive before the frame ends; keep it for WAIT_CK.
            if (((state_reg == COLLECT) || (state_reg == WAIT_CK)) && ck_done) begin
                done_lat_reg <= 1'b1;
                kill_lat_reg <= ck_kill;
            end

            case (state_reg)
                IDLE: begin
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    timer_reg    <= '0;
                    overflow_reg <= 1'b0;
                    done_lat_reg <= 1'b0;
                    kill_lat_reg <= 1'b0;
                    if (axiiv)
                        state_reg <= COLLECT;
                end

                COLLECT: begin
                    if (pack_word_valid) begin
                        if (wr_ptr_reg == PW'(DEPTH))
                            overflow_reg <= 1'b1;
                        else
                            wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    end
                    if (!axiiv)
                        state_reg <= WAIT_CK;
                end

                WAIT_CK: begin
                    if (frame_bad || (done_lat_reg && kill_lat_reg)) begin
                        state_reg  <= IDLE;
                        frame_drop <= 1'b1;
                        drop_cnt   <= sat_inc8(drop_cnt);
                    end else if (done_lat_reg) begin
                        state_reg  <= DRAIN;
                        out_valid  <= 1'b1;
                        out_data   <= frame_mem[0];
                        out_last   <= (wr_ptr_reg == PW'(1));
                        rd_ptr_reg <= PW'(1);
                    end else if (timer_reg == TW'(TIMEOUT - 1)) begin
                        state_reg  <= IDLE;
                        frame_drop <= 1'b1;
                        drop_cnt   <= sat_inc8(drop_cnt);
                    end else begin
                        timer_reg <= timer_reg + TW'(1);
                    end
                end

                DRAIN: begin
                    // rd_ptr_reg always points at the word after the one on out_data.
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= '0;
                            frame_ok  <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            out_data   <= frame_mem[rd_ptr_reg[AW-1:0]];
                            out_last   <= (rd_ptr_reg == (wr_ptr_reg - PW'(1)));
                            rd_ptr_reg <= rd_ptr_reg + PW'(1);
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: frame buffer capacity in 32-bit words.
REQ-002 Parameter TIMEOUT, default 255: max cycles waited in WAIT_CK for checksum verdict.
REQ-003 clk  input  1  RMII reference clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 axiiv  input  1  dibit valid from firewall stage.
REQ-006 axiid  input  2  dibit data, first dibit of a word is most significant.
REQ-007 ck_done  input  1  checksum verdict strobe from cksum stage.
REQ-008 ck_kill  input  1  checksum failed; qualified by ck_done.
REQ-009 out_ready  input  1  downstream accepts word.
REQ-010 out_valid  output  1  out_data holds a committed word.
REQ-011 out_data  output  32  committed frame word.
REQ-012 out_last  output  1  current word is final word of frame.
REQ-013 frame_ok  output  1  one-cycle pulse, frame fully drained.
REQ-014 frame_drop  output  1  one-cycle pulse, frame discarded.
REQ-015 busy  output  1  high in WAIT_CK and DRAIN; input dibits ignored.
REQ-016 drop_cnt  output  8  saturating count of discarded frames.

Function
REQ-017 States IDLE, COLLECT, WAIT_CK, DRAIN; one-hot or enum, single FSM.
REQ-018 IDLE->COLLECT on axiiv=1; that dibit is captured as dibit 0 of word 0.
REQ-019 COLLECT: each axiiv=1 cycle shifts axiid into packer; 16th dibit writes word to buf[wr_ptr], wr_ptr++.
REQ-020 COLLECT->WAIT_CK on first cycle with axiiv=0; partial word (<16 dibits) discarded.
REQ-021 Word count > DEPTH sets overflow flag; excess words not written; frame later dropped.
REQ-022 ck_done latched (with ck_kill) in COLLECT and WAIT_CK; done arriving in COLLECT is honoured.
REQ-023 WAIT_CK->DRAIN when latched done=1, kill=0, overflow=0, word count>=1.
REQ-024 WAIT_CK->IDLE with frame_drop pulse when latched done with kill=1, or overflow, or zero words.
REQ-025 WAIT_CK->IDLE with frame_drop pulse after TIMEOUT cycles without done.
REQ-026 DRAIN: out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==count-1); out_data stable while out_valid & !out_ready.
REQ-027 Transfer on out_valid & out_ready; last transfer -> IDLE, frame_ok pulse same cycle as IDLE entry (registered, next cycle after transfer).
REQ-028 axiiv during WAIT_CK/DRAIN ignored; a frame so ignored is not counted in drop_cnt.
REQ-029 drop_cnt increments on each frame_drop, saturates at 255.
REQ-030 ck_done outside COLLECT/WAIT_CK ignored.
REQ-031 Latency: first word out_valid 1 cycle after WAIT_CK decision.

Reset
REQ-032 rst forces IDLE; out_valid, out_last, frame_ok, frame_drop, busy=0; out_data=0; drop_cnt=0; pointers, latches, overflow cleared.
REQ-033 rst mid-frame or mid-drain abandons frame without frame_drop pulse; buffer contents need not be cleared.

Structure
REQ-034 Package rx_ctrl_pkg holds state enum, default DEPTH, TIMEOUT, word width 32.
REQ-035 Sub-module dibit_pack: 16-dibit shift register with count, emits word and word-valid pulse.

Verification
REQ-036 64 dibits 2'b10 then axiiv=0, ck_done=1/ck_kill=0, out_ready=1 -> 4 words 32'hAAAAAAAA, out_last on 4th, one frame_ok.
REQ-037 Same frame, ck_kill=1 -> no out_valid, one frame_drop, drop_cnt=1.
REQ-038 160 dibits (10 words, DEPTH=8) with good checksum -> frame_drop, no output.
REQ-039 Good 2-word frame, out_ready toggling 1/0 -> out_data held while stalled, exactly 2 transfers.
REQ-040 Frame ends, no ck_done for 256 cycles -> frame_drop after TIMEOUT, return IDLE.
REQ-041 rst asserted mid-DRAIN -> outputs zero immediately, next frame of 16 dibits 2'b01 yields 32'h55555555.
